// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous circular-buffer FIFO with flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);
    import cpu_pkg::*;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC, imem requests, prefetch FIFO,
//               redirect flush. Optional counters under FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);
    import cpu_pkg::*;

    localparam int              CNT_W    = $clog2(BUF_DEPTH) + 1;
    localparam int              USE_W    = CNT_W + 1;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [USE_W-1:0] CREDITS = USE_W'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            epoch_q, epoch_d;
    logic            infl_vld_q, infl_vld_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic            infl_epoch_q, infl_epoch_d;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [2*XLEN-1:0]  w_head;
    logic               w_pop;
    logic               w_push;
    logic               w_resp_ok;
    logic [USE_W-1:0]   w_used;
    logic               w_req;

    assign w_pop     = !w_fifo_empty && inst_ready && !redirect_valid;
    assign w_resp_ok = infl_vld_q && (infl_epoch_q == epoch_q);
    assign w_push    = w_resp_ok && !redirect_valid && (!w_fifo_full || w_pop);

    // Credits count the slot freed by a same-cycle pop, so streaming never bubbles.
    assign w_used = USE_W'(w_fifo_count) + USE_W'(infl_vld_q) - USE_W'(w_pop);
    assign w_req  = (state_q != ST_BOOT) && !redirect_valid && (w_used < CREDITS);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        epoch_d      = epoch_q;
        infl_vld_d   = w_req;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = infl_epoch_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            epoch_d    = ~epoch_q;
            state_d    = ST_FETCH;
        end else begin
            if (w_req) begin
                fetch_pc_d   = fetch_pc_q + PC_STEP;
                infl_pc_d    = fetch_pc_q;
                infl_epoch_d = epoch_q;
            end
            unique case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: state_d = w_req ? ST_FETCH : ST_HOLD;
                ST_HOLD:  state_d = w_pop ? ST_FETCH : ST_HOLD;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_vld_q   <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            infl_vld_q   <= infl_vld_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({imem_rdata, infl_pc_q}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count),
        .head_data (w_head)
    );

    assign imem_req   = w_req;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !w_fifo_empty;
    assign inst       = w_head[2*XLEN-1:XLEN];
    assign inst_pc    = w_head[XLEN-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        w_stall;

    assign w_stall = (state_q == ST_HOLD) || (w_fifo_empty && (state_q != ST_BOOT));

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (w_pop && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (w_stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    // Counters absent in this build.
`endif

endmodule
`default_nettype wire
